band_meter: RTL

- Downstream consumer of the seven 8-bit band magnitudes (freq1..freq7) from the frequency-processing stage.
- Per band, produces a display-ready level with instant attack and frame-rate linear decay.
- Per band, also keeps a peak-hold marker with a hold timer and its own decay.
- Feeds the spectrum display through packed outputs and a registered per-band read port.

---
 rtl/band_meter_if.sv | 31 +++
 rtl/band_meter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/band_meter_if.sv
// Bus bundle between the spectrum processing chain, band_meter and the display.
// Carries the sample strobe, seven band magnitudes, read-port select and all meter outputs.
// slave = meter side, master = driver/display side.
interface band_meter_if;
  logic        ready;
  logic [7:0]  freq1;
  logic [7:0]  freq2;
  logic [7:0]  freq3;
  logic [7:0]  freq4;
  logic [7:0]  freq5;
  logic [7:0]  freq6;
  logic [7:0]  freq7;
  logic        clear_clip;
  logic [2:0]  rd_sel;
  logic [55:0] levels;
  logic [55:0] peaks;
  logic [7:0]  rd_level;
  logic [7:0]  rd_peak;
  logic        frame_tick;
  logic [6:0]  clip;

  modport slave (
    input  ready, freq1, freq2, freq3, freq4, freq5, freq6, freq7, clear_clip, rd_sel,
    output levels, peaks, rd_level, rd_peak, frame_tick, clip
  );

  modport master (
    output ready, freq1, freq2, freq3, freq4, freq5, freq6, freq7, clear_clip, rd_sel,
    input  levels, peaks, rd_level, rd_peak, frame_tick, clip
  );
endinterface

// File: rtl/band_meter.sv
// Seven-band display meter: instant-attack levels with per-frame linear decay, plus held peaks.
// Latency: levels/peaks change one cycle after the ready strobe; rd_level/rd_peak one cycle after rd_sel.
// No backpressure: ready is a free-running sample strobe. Optional sticky clip flags: BAND_METER_CLIP_LATCH_EN.
module band_meter #(
  parameter int FRAME_SAMPLES = 1024,
  parameter int DECAY_STEP    = 4,
  parameter int PEAK_DECAY    = 2,
  parameter int HOLD_FRAMES   = 30
) (
  input logic         clock,
  input logic         reset,
  band_meter_if.slave bus
);

  localparam int CW = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_SAMPLES - 1);
  localparam logic [8:0]    DSTEP     = 9'(DECAY_STEP);
  localparam logic [8:0]    PSTEP     = 9'(PEAK_DECAY);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);

  // Saturating subtract done 9 bits wide so a small value never wraps to a large one.
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [8:0] b);
    sat_sub = ({1'b0, a} >= b) ? (a - b[7:0]) : 8'd0;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    max8 = (a > b) ? a : b;
  endfunction

  logic [6:0][7:0]    freq;
  logic [6:0][7:0]    arrive;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [6:0][7:0]    level_q, level_d;
  logic [6:0][7:0]    peak_q, peak_d;
  logic [6:0][HW-1:0] hold_q, hold_d;
  logic [7:0]         rd_level_q, rd_level_d;
  logic [7:0]         rd_peak_q, rd_peak_d;
  logic [6:0]         clip_q, clip_d;

  assign freq = {bus.freq7, bus.freq6, bus.freq5, bus.freq4, bus.freq3, bus.freq2, bus.freq1};

  // Sample counter: wraps after FRAME_SAMPLES strobes and flags the frame for the next cycle.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (bus.ready) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Per-band level and peak update; peak logic sees the level value being written this cycle.
  always_comb begin
    level_d = level_q;
    peak_d  = peak_q;
    hold_d  = hold_q;
    arrive  = '0;
    for (int b = 0; b < 7; b++) begin
      arrive[b] = bus.ready ? freq[b] : 8'd0;
      if (tick_q) begin
        level_d[b] = max8(sat_sub(level_q[b], DSTEP), arrive[b]);
      end else if (bus.ready) begin
        level_d[b] = max8(level_q[b], freq[b]);
      end
      if (level_d[b] > peak_q[b]) begin
        peak_d[b] = level_d[b];
        hold_d[b] = HOLD_INIT;
      end else if (tick_q) begin
        if (hold_q[b] != '0) begin
          hold_d[b] = hold_q[b] - HW'(1);
        end else begin
          peak_d[b] = max8(sat_sub(peak_q[b], PSTEP), level_d[b]);
        end
      end
    end
  end

  // Read port samples the current registers; select 7 is out of range and reads zero.
  always_comb begin
    rd_level_d = 8'd0;
    rd_peak_d  = 8'd0;
    if (bus.rd_sel < 3'd7) begin
      rd_level_d = level_q[bus.rd_sel];
      rd_peak_d  = peak_q[bus.rd_sel];
    end
  end

`ifdef BAND_METER_CLIP_LATCH_EN
  // Sticky clip per band: a full-scale sample sets it, clear_clip drops it, a same-cycle set wins.
  always_comb begin
    clip_d = clip_q;
    for (int b = 0; b < 7; b++) begin
      clip_d[b] = (bus.ready && (freq[b] == 8'hFF)) || (clip_q[b] && !bus.clear_clip);
    end
  end
`else
  logic clear_clip_unused;
  assign clear_clip_unused = bus.clear_clip;
  assign clip_d = '0;
`endif

  // State registers; reset discards any partial frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      level_q    <= '0;
      peak_q     <= '0;
      hold_q     <= '0;
      rd_level_q <= 8'd0;
      rd_peak_q  <= 8'd0;
      clip_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      level_q    <= level_d;
      peak_q     <= peak_d;
      hold_q     <= hold_d;
      rd_level_q <= rd_level_d;
      rd_peak_q  <= rd_peak_d;
      clip_q     <= clip_d;
    end
  end

  assign bus.levels     = level_q;
  assign bus.peaks      = peak_q;
  assign bus.rd_level   = rd_level_q;
  assign bus.rd_peak    = rd_peak_q;
  assign bus.frame_tick = tick_q;
  assign bus.clip       = clip_q;

endmodule
